response_misr_checker: RTL
==========================

# response_misr_checker

Synthesizable response-side companion to the fuzz stimulus benches. Stimulus is replayed into `top`, and this block consumes the wide `y` output stream instead of `$strobe`-printing it. It folds each sampled output word into a multiple-input signature register (MISR) and, after a programmed number of vectors, compares the signature against an expected value. It sits next to `top` in identity/equivalence runs, so a run reduces to one pass/fail bit plus a signature.

## Interface
- `WIDTH`, 1490 — width of the observed DUT output `y`.
- `SIG_W`, 32 — signature width; `WIDTH` need not be a multiple of it.
- `NUM_VECTORS`, 20 — number of valid samples per run; must be ≥ 1.
- `POLY`, 32'h04C11DB7 — MISR feedback polynomial, `SIG_W` bits.
- `SEED`, 32'hFFFFFFFF — signature value loaded at `start`.
- `clk` input 1 — sole clock; all logic on `posedge clk`.
- `rst_n` input 1 — reset, synchronous, active-low.
- `start` input 1 — begin a run; honoured in IDLE or DONE only.
- `y_valid` input 1 — `y` holds a sample to absorb this cycle.
- `y` input `WIDTH` — DUT output word.
- `expected_sig` input `SIG_W` — golden signature; sampled on the final-sample edge.
- `busy` output 1 — high in RUN.
- `done` output 1 — high in DONE.
- `pass` output 1 — final comparison result; valid only while `done`=1.
- `signature` output `SIG_W` — current MISR contents.
- `count` output `$clog2(NUM_VECTORS+1)` — samples absorbed in the current run.

## Operation
- Fold: split `y` into ceil(`WIDTH`/`SIG_W`) chunks from the LSB. Zero-pad the top chunk. `fold` = XOR of all chunks.
- MISR step: `sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold`.
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- IDLE/DONE with `start`=1: `signature`←`SEED`, `count`←0, `pass`←0, go to RUN.
- DONE with `start`=0: hold all outputs.
- RUN with `y_valid`=1: `signature`←`sig_next`, `count`←`count`+1.
- RUN with `y_valid`=0: hold all outputs; gaps of any length are allowed.
- RUN, `y_valid`=1 and `count`==`NUM_VECTORS`-1 (final sample): apply the MISR step, `pass`←(`sig_next`==`expected_sig`), go to DONE.
- `start` during RUN: ignored, no restart.
- `y_valid` outside RUN: ignored; signature and count unchanged.
- `start` and `y_valid` on the same IDLE/DONE cycle: start wins and the sample is not absorbed.

## Timing
- Reset (`rst_n`=0 at a `posedge clk`), including mid-run:
  - state←IDLE.
  - `busy`=0, `done`=0, `pass`=0.
  - `signature`=`SEED`, `count`=0.
- Reset has priority over every other input.
- `busy` rises the cycle after `start` is sampled.
- Each absorbed sample is visible on `signature`/`count` one cycle after its edge.
- `done` and `pass` update on the same edge that absorbs the final sample, so they are valid in the following cycle.
- Minimum run length is `NUM_VECTORS`+1 cycles from `start` to `done`.
- Back-to-back runs: asserting `start` in the first DONE cycle gives `busy` on the next cycle.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
Bench parameters: `WIDTH`=64, `SIG_W`=8, `POLY`=8'h07, `SEED`=8'h00, `NUM_VECTORS`=2.
- Basic pass: `start`, then valid `y`=64'h1, then valid `y`=64'h0, `expected_sig`=8'h02 -> `signature` goes 01 then 02; `done`=1, `pass`=1, `count`=2.
- Mismatch: same stimulus with `expected_sig`=8'h03 -> `done`=1, `pass`=0, `signature`=8'h02.
- Fold cancellation: valid `y`=64'h0101010101010101 twice, `expected_sig`=8'h00 -> fold=0 each step, `signature` stays 00, `pass`=1.
- Feedback path: `SEED`=8'h80, `NUM_VECTORS`=1, valid `y`=0 -> `signature`=8'h07.
- Gaps and ignored inputs: 3 idle cycles between the two samples, plus `start` pulsed mid-run -> results identical to the basic-pass case; `busy` stays 1 until the final sample.
- Reset mid-run: `rst_n`=0 after the first sample -> next cycle IDLE, `count`=0, `signature`=`SEED`; a fresh run then passes.

Source files
------------

// File: rtl/response_misr_checker.sv
// Response-side signature checker: folds each valid wide output word into a MISR
// and compares the final signature against a golden value after NUM_VECTORS samples.
module response_misr_checker #(
    parameter int                WIDTH       = 1490,
    parameter int                SIG_W       = 32,
    parameter int                NUM_VECTORS = 20,
    parameter logic [SIG_W-1:0]  POLY        = 32'h04C11DB7,
    parameter logic [SIG_W-1:0]  SEED        = 32'hFFFFFFFF,
    localparam int               CNT_W       = $clog2(NUM_VECTORS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             y_valid,
    input  logic [WIDTH-1:0] y,
    input  logic [SIG_W-1:0] expected_sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] count
);

    localparam int             NCH   = (WIDTH + SIG_W - 1) / SIG_W;
    localparam int             PAD_W = NCH * SIG_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [PAD_W-1:0] y_padded;
    logic [SIG_W-1:0] fold;
    logic [SIG_W-1:0] sig_next;

    // Zero-extension pads the top chunk when WIDTH is not a multiple of SIG_W.
    assign y_padded = PAD_W'(y);

    // NOTE: fold gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        fold = '0;
        for (int i = 0; i < NCH; i++) begin
            fold = fold ^ y_padded[i*SIG_W +: SIG_W];
        end
    end

    assign sig_next = {signature[SIG_W-2:0], 1'b0}
                    ^ (signature[SIG_W-1] ? POLY : '0)
                    ^ fold;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= SEED;
            count     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        signature <= SEED;
                        count     <= '0;
                    end
                end
                RUN: begin
                    if (y_valid) begin
                        signature <= sig_next;
                        count     <= count + 1'b1;
                        if (count == LAST) begin
                            pass  <= (sig_next == expected_sig);
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
